pe_command_issuer: RTL and testbench
====================================

PE_COMMAND_ISSUER -- requirements
Module: pe_command_issuer

Interface
REQ-001 SHALL have parameter depth, default 2, meaning log2 of the PE count.
REQ-002 SHALL have parameter A, default 7, meaning the width of the per-PE word counts.
REQ-003 SHALL have parameter CTR_IP, default 2, meaning the width of the command bus.
REQ-004 SHALL have parameter D, default (1<<depth), meaning the number of PEs.
REQ-005 SHALL have parameter W, default 16, meaning the data word width.
REQ-006 SHALL have port CLK  input  1  single clock; all state updates on the rising edge.
REQ-007 SHALL have port RSTN  input  1  reset; asynchronous and active-low.
REQ-008 SHALL have port start  input  1  requests one layer sequence; sampled only in IDLE.
REQ-009 SHALL have port kernelCount  input  A  kernel words per PE; latched at accepted start.
REQ-010 SHALL have port neuronCount  input  A  broadcast neuron words; latched at accepted start.
REQ-011 SHALL have port computeCycles  input  A  COMPUTE cycle count; latched at accepted start.
REQ-012 SHALL have port inData  input  W  upstream data word.
REQ-013 SHALL have port inValid  input  1  upstream word valid.
REQ-014 SHALL have port inReady  output  1  issuer accepts a word; a transfer occurs when inValid and inReady are both 1.
REQ-015 SHALL have port controlSignal  output  CTR_IP  command to the PE local store controllers: 00 IDLE, 01 LOAD_KERNEL, 10 LOAD_NEURON, 11 COMPUTE.
REQ-016 SHALL have port peData  output  W  word delivered to the PEs.
REQ-017 SHALL have port peSelect  output  D  per-PE enable, one bit per PE.
REQ-018 SHALL have port busy  output  1  sequence in progress.
REQ-019 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-020 SHALL implement states IDLE, LOAD_K, LOAD_N, COMPUTE and DONE, with an A-bit word counter wordCnt and a depth-bit PE counter peCnt.
REQ-021 SHALL, in IDLE with start=1, latch all three counts, clear both counters and go to the first state in the order LOAD_K, LOAD_N, COMPUTE whose count is nonzero, or to DONE if all counts are 0.
REQ-022 SHALL drive inReady=1 only in LOAD_K and LOAD_N, combinationally from the state.
REQ-023 SHALL register controlSignal, peData and peSelect one cycle after each transfer; a transfer on edge n appears during cycle n+1 and holds for exactly one cycle.
REQ-024 SHALL, in LOAD_K, issue controlSignal=01 and peSelect = one-hot(peCnt) for each transfer, then increment wordCnt.
REQ-025 SHALL, in LOAD_K at wordCnt==kernelCount-1, clear wordCnt and increment peCnt; if peCnt==D-1 it SHALL also clear peCnt and advance to the next nonzero phase.
REQ-026 SHALL, in LOAD_N, issue controlSignal=10 with peSelect all ones for each transfer; at the last of neuronCount transfers it SHALL advance.
REQ-027 SHALL, in any cycle without a transfer, drive controlSignal=00 and peSelect=0 and hold peData; counters SHALL hold during inValid bubbles.
REQ-028 SHALL, in COMPUTE, drive controlSignal=11, peSelect all ones and inReady=0 for exactly computeCycles consecutive cycles, then go to DONE.
REQ-029 SHALL drive done=1 for exactly the single cycle spent in DONE, then return to IDLE.
REQ-030 SHALL drive busy=1 in every state except IDLE.
REQ-031 SHALL ignore start while busy=1; input count changes after latching SHALL NOT affect a running sequence.
REQ-032 SHALL support a maximum count of 2^A-1 (127) without counter wrap or early exit.

Reset
REQ-033 SHALL, while RSTN=0 (async, including mid-operation), force state=IDLE, wordCnt=peCnt=0, controlSignal=00, peData=0, peSelect=0, busy=0, done=0 and inReady=0; latched counts SHALL be discarded.

Verification (D=4, A=7)
REQ-034 SHALL verify: kernelCount=2, neuronCount=3, computeCycles=4, inValid held 1 -> 8 LOAD_KERNEL issues with peSelect 0001,0001,0010,0010,0100,0100,1000,1000; then 3 LOAD_NEURON issues with 1111; then 4 COMPUTE cycles; then one done pulse.
REQ-035 SHALL verify: inValid dropped for 2 cycles during LOAD_K -> controlSignal=00 and peSelect=0 for those cycles, peData held, and no words lost or duplicated.
REQ-036 SHALL verify: all counts 0, start at edge k -> busy=1 and done=1 during cycle k+1, then IDLE with no data issued.
REQ-037 SHALL verify: kernelCount=0, neuronCount=1, computeCycles=0 -> LOAD_K is skipped, a single 10/1111 issue occurs, then DONE.
REQ-038 SHALL verify: RSTN pulsed low mid-LOAD_N -> all outputs 0 immediately, without waiting for a clock edge; a subsequent start begins a fresh sequence.
REQ-039 SHALL verify: start re-asserted while busy and kernelCount=127 with inValid=1 -> start is ignored and 508 kernel issues occur before LOAD_N.

Source files
------------

// File: rtl/pe_command_issuer.sv
// rtl/pe_command_issuer.sv - Sequences kernel loads, neuron broadcast and compute commands to a PE array.
module pe_command_issuer #(
   parameter int depth  = 2,
   parameter int A      = 7,
   parameter int CTR_IP = 2,
   parameter int D      = (1 << depth),
   parameter int W      = 16
) (
   input  logic              CLK,
   input  logic              RSTN,
   input  logic              start,
   input  logic [A-1:0]      kernelCount,
   input  logic [A-1:0]      neuronCount,
   input  logic [A-1:0]      computeCycles,
   input  logic [W-1:0]      inData,
   input  logic              inValid,
   output logic              inReady,
   output logic [CTR_IP-1:0] controlSignal,
   output logic [W-1:0]      peData,
   output logic [D-1:0]      peSelect,
   output logic              busy,
   output logic              done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_K,
      S_LOAD_N,
      S_COMPUTE,
      S_DONE
   } state_t;

   localparam logic [CTR_IP-1:0] CMD_IDLE    = CTR_IP'(0);
   localparam logic [CTR_IP-1:0] CMD_KERNEL  = CTR_IP'(1);
   localparam logic [CTR_IP-1:0] CMD_NEURON  = CTR_IP'(2);
   localparam logic [CTR_IP-1:0] CMD_COMPUTE = CTR_IP'(3);
   localparam logic [depth-1:0]  PE_LAST     = depth'(D - 1);

   state_t              r_state;
   logic [A-1:0]        r_k;
   logic [A-1:0]        r_n;
   logic [A-1:0]        r_c;
   logic [A-1:0]        r_word_cnt;
   logic [depth-1:0]    r_pe_cnt;
   logic [CTR_IP-1:0]   r_ctrl;
   logic [W-1:0]        r_data;
   logic [D-1:0]        r_sel;

   state_t              w_next;
   state_t              w_first;
   state_t              w_after_k;
   state_t              w_after_n;
   logic [A-1:0]        w_word_nxt;
   logic [depth-1:0]    w_pe_nxt;
   logic [CTR_IP-1:0]   w_ctrl_nxt;
   logic [W-1:0]        w_data_nxt;
   logic [D-1:0]        w_sel_nxt;
   logic                w_xfer;

   assign inReady       = (r_state == S_LOAD_K) || (r_state == S_LOAD_N);
   assign w_xfer        = inValid && inReady;
   assign busy          = (r_state != S_IDLE);
   assign done          = (r_state == S_DONE);
   assign controlSignal = r_ctrl;
   assign peData        = r_data;
   assign peSelect      = r_sel;

   // Phases with a zero count are skipped entirely.
   assign w_first   = (kernelCount   != '0) ? S_LOAD_K  :
                      (neuronCount   != '0) ? S_LOAD_N  :
                      (computeCycles != '0) ? S_COMPUTE : S_DONE;
   assign w_after_k = (r_n != '0) ? S_LOAD_N  :
                      (r_c != '0) ? S_COMPUTE : S_DONE;
   assign w_after_n = (r_c != '0) ? S_COMPUTE : S_DONE;

   always_comb begin
      w_next     = r_state;
      w_word_nxt = r_word_cnt;
      w_pe_nxt   = r_pe_cnt;
      w_ctrl_nxt = CMD_IDLE;
      w_sel_nxt  = '0;
      w_data_nxt = r_data;
      unique case (r_state)
         S_IDLE: begin
            if (start) begin
               w_next     = w_first;
               w_word_nxt = '0;
               w_pe_nxt   = '0;
            end
         end
         S_LOAD_K: begin
            if (w_xfer) begin
               w_ctrl_nxt = CMD_KERNEL;
               w_sel_nxt  = D'(1) << r_pe_cnt;
               w_data_nxt = inData;
               if (r_word_cnt == r_k - A'(1)) begin
                  w_word_nxt = '0;
                  if (r_pe_cnt == PE_LAST) begin
                     w_pe_nxt = '0;
                     w_next   = w_after_k;
                  end else begin
                     w_pe_nxt = r_pe_cnt + depth'(1);
                  end
               end else begin
                  w_word_nxt = r_word_cnt + A'(1);
               end
            end
         end
         S_LOAD_N: begin
            if (w_xfer) begin
               w_ctrl_nxt = CMD_NEURON;
               w_sel_nxt  = '1;
               w_data_nxt = inData;
               if (r_word_cnt == r_n - A'(1)) begin
                  w_word_nxt = '0;
                  w_next     = w_after_n;
               end else begin
                  w_word_nxt = r_word_cnt + A'(1);
               end
            end
         end
         S_COMPUTE: begin
            w_ctrl_nxt = CMD_COMPUTE;
            w_sel_nxt  = '1;
            if (r_word_cnt == r_c - A'(1)) begin
               w_word_nxt = '0;
               w_next     = S_DONE;
            end else begin
               w_word_nxt = r_word_cnt + A'(1);
            end
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         r_state    <= S_IDLE;
         r_k        <= '0;
         r_n        <= '0;
         r_c        <= '0;
         r_word_cnt <= '0;
         r_pe_cnt   <= '0;
         r_ctrl     <= CMD_IDLE;
         r_data     <= '0;
         r_sel      <= '0;
      end else begin
         r_state    <= w_next;
         r_word_cnt <= w_word_nxt;
         r_pe_cnt   <= w_pe_nxt;
         r_ctrl     <= w_ctrl_nxt;
         r_data     <= w_data_nxt;
         r_sel      <= w_sel_nxt;
         if (r_state == S_IDLE && start) begin
            r_k <= kernelCount;
            r_n <= neuronCount;
            r_c <= computeCycles;
         end
      end
   end

endmodule

// File: tb/tb_pe_command_issuer.sv
// tb/tb_pe_command_issuer.sv - Randomized timeline-model bench for pe_command_issuer.
module tb_pe_command_issuer;

   localparam int DEPTH  = 2;
   localparam int A      = 7;
   localparam int CTR_IP = 2;
   localparam int D      = 4;
   localparam int W      = 16;
   localparam int MAXC   = 4000;

   logic              CLK = 1'b0;
   logic              RSTN;
   logic              start;
   logic [A-1:0]      kernelCount;
   logic [A-1:0]      neuronCount;
   logic [A-1:0]      computeCycles;
   logic [W-1:0]      inData;
   logic              inValid;
   logic              inReady;
   logic [CTR_IP-1:0] controlSignal;
   logic [W-1:0]      peData;
   logic [D-1:0]      peSelect;
   logic              busy;
   logic              done;

   int vectors     = 0;
   int miscompares = 0;
   logic [W-1:0] last_data;

   pe_command_issuer #(
      .depth (DEPTH),
      .A     (A),
      .CTR_IP(CTR_IP),
      .D     (D),
      .W     (W)
   ) dut (
      .CLK          (CLK),
      .RSTN         (RSTN),
      .start        (start),
      .kernelCount  (kernelCount),
      .neuronCount  (neuronCount),
      .computeCycles(computeCycles),
      .inData       (inData),
      .inValid      (inValid),
      .inReady      (inReady),
      .controlSignal(controlSignal),
      .peData       (peData),
      .peSelect     (peSelect),
      .busy         (busy),
      .done         (done)
   );

   always #5 CLK = ~CLK;

   // Timeline model: the start edge is edge 0, cycle t lies between edges t-1 and t.
   // A word accepted at edge t is issued during cycle t+1. With T the edge of the last
   // load (or the start edge), compute shows in cycles T+2..T+1+c and done in the final cycle.
   task automatic run_seq(input string name, input int k, input int n, input int c,
                          input int vmode, input bit hammer);
      int               ctrl_q[$];
      logic [D-1:0]     sel_q[$];
      int               L, T, dcyc, xfers, t;
      bit               prev_xfer, finished;
      logic [1:0]       item_ctrl, e_ctrl;
      logic [D-1:0]     item_sel, e_sel;
      logic [W-1:0]     prev_data;
      logic             e_busy, e_done, e_ready;
      for (int pe = 0; pe < D; pe++)
         for (int w = 0; w < k; w++) begin
            ctrl_q.push_back(1);
            sel_q.push_back(D'(1) << pe);
         end
      for (int i = 0; i < n; i++) begin
         ctrl_q.push_back(2);
         sel_q.push_back('1);
      end
      L = ctrl_q.size();
      @(negedge CLK);
      kernelCount   = A'(k);
      neuronCount   = A'(n);
      computeCycles = A'(c);
      start         = 1'b1;
      inValid       = 1'b0;
      inData        = W'($urandom);
      xfers     = 0;
      prev_xfer = 1'b0;
      prev_data = '0;
      item_ctrl = '0;
      item_sel  = '0;
      T         = (L == 0) ? 0 : -1;
      dcyc      = -1;
      finished  = 1'b0;
      t         = 1;
      while (t <= MAXC && !finished) begin
         @(negedge CLK);
         if (T >= 0) dcyc = (c > 0) ? T + 1 + c : T + 1;
         e_busy  = (dcyc < 0) || (t <= dcyc);
         e_done  = (t == dcyc);
         e_ready = (xfers < L);
         if (prev_xfer) begin
            last_data = prev_data;
            e_ctrl    = item_ctrl;
            e_sel     = item_sel;
         end else if (T >= 0 && t >= T + 2 && t <= T + 1 + c) begin
            e_ctrl = 2'd3;
            e_sel  = '1;
         end else begin
            e_ctrl = 2'd0;
            e_sel  = '0;
         end
         vectors++;
         if ({busy, done, inReady, controlSignal, peSelect, peData} !==
             {e_busy, e_done, e_ready, e_ctrl, e_sel, last_data}) begin
            miscompares++;
            $display("FAIL %s cycle %0d busy/done/rdy/ctrl/sel/data got %b/%b/%b/%b/%b/%h exp %b/%b/%b/%b/%b/%h",
                     name, t, busy, done, inReady, controlSignal, peSelect, peData,
                     e_busy, e_done, e_ready, e_ctrl, e_sel, last_data);
         end
         if (dcyc >= 0 && t > dcyc) begin
            start    = 1'b0;
            inValid  = 1'b0;
            finished = 1'b1;
         end else begin
            start = hammer;
            if (hammer) begin
               kernelCount   = A'($urandom);
               neuronCount   = A'($urandom);
               computeCycles = A'($urandom);
            end
            case (vmode)
               0:       inValid = 1'b1;
               1:       inValid = ($urandom_range(0, 9) < 7);
               default: inValid = !(t == 3 || t == 4);
            endcase
            inData    = W'($urandom);
            prev_xfer = inValid && (xfers < L);
            if (prev_xfer) begin
               item_ctrl = 2'(ctrl_q.pop_front());
               item_sel  = sel_q.pop_front();
               prev_data = inData;
               xfers++;
               if (xfers == L) T = t;
            end
            t++;
         end
      end
      if (!finished) begin
         vectors++;
         miscompares++;
         $display("FAIL %s timeout: sequence did not complete in %0d cycles (xfers %0d of %0d)",
                  name, MAXC, xfers, L);
         start   = 1'b0;
         inValid = 1'b0;
      end
   endtask

   task automatic test_reset;
      RSTN          = 1'b0;
      start         = 1'b0;
      kernelCount   = '0;
      neuronCount   = '0;
      computeCycles = '0;
      inData        = '0;
      inValid       = 1'b1;
      last_data     = '0;
      repeat (3) @(negedge CLK);
      vectors++;
      if ({busy, done, inReady, controlSignal, peSelect, peData} !== 25'd0) begin
         miscompares++;
         $display("FAIL reset_state got busy/done/rdy/ctrl/sel/data %b/%b/%b/%b/%b/%h exp all zero",
                  busy, done, inReady, controlSignal, peSelect, peData);
      end
      RSTN    = 1'b1;
      inValid = 1'b0;
   endtask

   task automatic test_reset_mid;
      @(negedge CLK);
      kernelCount   = 7'd1;
      neuronCount   = 7'd5;
      computeCycles = 7'd2;
      inData        = 16'hA5A5;
      inValid       = 1'b1;
      start         = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      repeat (6) @(negedge CLK);
      vectors++;
      if ({busy, inReady, controlSignal, peSelect, peData} !== {1'b1, 1'b1, 2'd2, 4'hF, 16'hA5A5}) begin
         miscompares++;
         $display("FAIL mid_load_n got busy/rdy/ctrl/sel/data %b/%b/%b/%b/%h exp 1/1/10/1111/a5a5",
                  busy, inReady, controlSignal, peSelect, peData);
      end
      #2 RSTN = 1'b0;
      #1;
      vectors++;
      if ({busy, done, inReady, controlSignal, peSelect, peData} !== 25'd0) begin
         miscompares++;
         $display("FAIL async_reset got busy/done/rdy/ctrl/sel/data %b/%b/%b/%b/%b/%h exp all zero",
                  busy, done, inReady, controlSignal, peSelect, peData);
      end
      @(negedge CLK);
      RSTN      = 1'b1;
      inValid   = 1'b0;
      last_data = '0;
   endtask

   task automatic test_basic;
      run_seq("basic", 2, 3, 4, 0, 1'b0);
   endtask

   task automatic test_bubbles;
      run_seq("bubble", 2, 1, 1, 2, 1'b0);
   endtask

   task automatic test_zero_counts;
      run_seq("zero", 0, 0, 0, 0, 1'b0);
   endtask

   task automatic test_skip_phases;
      run_seq("neuron_only", 0, 1, 0, 0, 1'b0);
      run_seq("compute_only", 0, 0, 3, 0, 1'b0);
      run_seq("kernel_only", 1, 0, 0, 1, 1'b0);
   endtask

   task automatic test_after_reset;
      test_reset_mid;
      run_seq("after_rst", 1, 2, 1, 0, 1'b0);
   endtask

   task automatic test_random;
      for (int i = 0; i < 8; i++)
         run_seq("random", $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5), 1, i[0]);
   endtask

   task automatic test_max_counts;
      run_seq("max_kernel", 127, 1, 1, 0, 1'b1);
      run_seq("max_n_c", 1, 127, 127, 1, 1'b0);
   endtask

   initial begin
      test_reset;
      test_basic;
      test_bubbles;
      test_zero_counts;
      test_skip_phases;
      test_after_reset;
      test_random;
      test_max_counts;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
